// File: rtl/alarm_clock_pkg.sv
// Shared encodings and sizing helpers for the alarm clock ring/snooze path.
package alarm_clock_pkg;

  // Ring controller state encodings, shared by the RTL and its bench.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZED = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_RINGING = RINGING,
    ST_SNOOZED = SNOOZED,
    ST_DONE    = DONE
  } ring_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned safe_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_sec_timer.sv
// Loadable, clearable seconds counter with a fixed direction and a
// terminal-count flag. Steps only on i_step and never runs past its limit.
module sec_timer #(
  parameter int unsigned     WIDTH    = 8,
  parameter bit              COUNT_UP = 1'b1,
  parameter logic [WIDTH-1:0] TC_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_limit;

  // Up counters stop at the terminal count, down counters stop at zero.
  assign w_at_limit = COUNT_UP ? (r_count == TC_VAL) : (r_count == '0);
  assign o_tc       = (r_count == TC_VAL);
  assign o_count    = r_count;

  // Counter register: clear beats load beats step.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_step && !w_at_limit) begin
      r_count <= COUNT_UP ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
    end
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Ring/snooze controller for one alarm: rings on trigger, supports a bounded
// number of snoozes, dismiss, and auto-silence after a fixed ring length.
module alarm_ring_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC  = 300,
  parameter int unsigned RING_SEC    = 60,
  parameter int unsigned MAX_SNOOZES = 3
) (
  input  logic                               clk_pi,
  input  logic                               rst_n_pi,
  input  logic                               sec_en_pi,
  input  logic                               alarm_en_pi,
  input  logic                               alarm_triggered_pi,
  input  logic                               snooze_pi,
  input  logic                               dismiss_pi,
  output logic                               ring_po,
  output logic                               snoozed_po,
  output logic [$clog2(SNOOZE_SEC+1)-1:0]    snooze_left_po,
  output logic [$clog2(MAX_SNOOZES+1)-1:0]   snooze_count_po
);

  localparam int unsigned RING_W = safe_width(RING_SEC);
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_SEC + 1);
  localparam int unsigned CNT_W  = $clog2(MAX_SNOOZES + 1);

  localparam logic [RING_W-1:0] RING_TC   = RING_W'(RING_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC);
  localparam logic [SNZ_W-1:0]  SNZ_TC    = SNZ_W'(1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_SNOOZES);

  ring_state_e       r_state;
  ring_state_e       w_next_state;
  logic [CNT_W-1:0]  r_snooze_count;

  logic              w_ring_clr;
  logic              w_ring_step;
  logic              w_ring_tc;
  logic [RING_W-1:0] w_ring_count;
  logic              w_snz_clr;
  logic              w_snz_load;
  logic              w_snz_step;
  logic              w_snz_tc;
  logic [SNZ_W-1:0]  w_snz_count;
  logic              w_cnt_clr;
  logic              w_cnt_inc;

  // Elapsed ring seconds; terminal count marks the last second before silence.
  sec_timer #(
    .WIDTH    (RING_W),
    .COUNT_UP (1'b1),
    .TC_VAL   (RING_TC)
  ) u_ring_timer (
    .clk        (clk_pi),
    .rst_n      (rst_n_pi),
    .i_clr      (w_ring_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_step     (w_ring_step),
    .o_count    (w_ring_count),
    .o_tc       (w_ring_tc)
  );

  // Remaining snooze seconds; terminal count at 1 means the next tick re-rings.
  sec_timer #(
    .WIDTH    (SNZ_W),
    .COUNT_UP (1'b0),
    .TC_VAL   (SNZ_TC)
  ) u_snooze_timer (
    .clk        (clk_pi),
    .rst_n      (rst_n_pi),
    .i_clr      (w_snz_clr),
    .i_load     (w_snz_load),
    .i_load_val (SNZ_LOAD),
    .i_step     (w_snz_step),
    .o_count    (w_snz_count),
    .o_tc       (w_snz_tc)
  );

  // State register.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and timer control; disabling the alarm overrides every state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_next_state = r_state;
    w_ring_clr   = 1'b0;
    w_ring_step  = 1'b0;
    w_snz_clr    = 1'b0;
    w_snz_load   = 1'b0;
    w_snz_step   = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    if (!alarm_en_pi) begin
      w_next_state = ST_IDLE;
      w_ring_clr   = 1'b1;
      w_snz_clr    = 1'b1;
      w_cnt_clr    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (alarm_triggered_pi) begin
            w_next_state = ST_RINGING;
            w_ring_clr   = 1'b1;
            w_cnt_clr    = 1'b1;
          end
        end
        ST_RINGING: begin
          if (dismiss_pi) begin
            w_next_state = ST_DONE;
          end else if (snooze_pi && (r_snooze_count < MAX_CNT)) begin
            w_next_state = ST_SNOOZED;
            w_snz_load   = 1'b1;
            w_cnt_inc    = 1'b1;
          end else if (sec_en_pi && w_ring_tc) begin
            w_next_state = ST_DONE;
          end else if (sec_en_pi) begin
            w_ring_step  = 1'b1;
          end
        end
        ST_SNOOZED: begin
          if (dismiss_pi) begin
            w_next_state = ST_DONE;
            w_snz_clr    = 1'b1;
          end else if (sec_en_pi && w_snz_tc) begin
            w_next_state = ST_RINGING;
            w_snz_clr    = 1'b1;
            w_ring_clr   = 1'b1;
          end else if (sec_en_pi) begin
            w_snz_step   = 1'b1;
          end
        end
        ST_DONE: begin
          if (!alarm_triggered_pi) begin
            w_next_state = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Snoozes used in the current alarm event; only incremented below the cap.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      r_snooze_count <= '0;
    end else if (w_cnt_clr) begin
      r_snooze_count <= '0;
    end else if (w_cnt_inc) begin
      r_snooze_count <= r_snooze_count + CNT_W'(1);
    end
  end

  // The ring timer must never run past its last second.
  ring_timer_bound_a : assert property (
    @(posedge clk_pi) disable iff (!rst_n_pi) w_ring_count <= RING_TC
  );

  assign ring_po         = (r_state == ST_RINGING);
  assign snoozed_po      = (r_state == ST_SNOOZED);
  assign snooze_left_po  = w_snz_count;
  assign snooze_count_po = r_snooze_count;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: a behavioural model predicts the
// outputs for each clock edge, the prediction is queued when stimulus is
// driven and popped when the DUT outputs settle.
module tb_alarm_ring_ctrl;
  import alarm_clock_pkg::*;

  localparam int SNZ  = 3;
  localparam int RING = 4;
  localparam int MAXS = 2;

  typedef struct {
    logic       ring;
    logic       snoozed;
    int         left;
    int         count;
  } exp_t;

  logic       clk_pi;
  logic       rst_n_pi;
  logic       sec_en_pi;
  logic       alarm_en_pi;
  logic       alarm_triggered_pi;
  logic       snooze_pi;
  logic       dismiss_pi;
  logic       ring_po;
  logic       snoozed_po;
  logic [1:0] snooze_left_po;
  logic [1:0] snooze_count_po;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  // Model state: remaining ring pulses instead of an elapsed count.
  logic [1:0] m_st;
  int         m_rem;
  int         m_left;
  int         m_cnt;

  alarm_ring_ctrl #(
    .SNOOZE_SEC  (SNZ),
    .RING_SEC    (RING),
    .MAX_SNOOZES (MAXS)
  ) dut (
    .clk_pi             (clk_pi),
    .rst_n_pi           (rst_n_pi),
    .sec_en_pi          (sec_en_pi),
    .alarm_en_pi        (alarm_en_pi),
    .alarm_triggered_pi (alarm_triggered_pi),
    .snooze_pi          (snooze_pi),
    .dismiss_pi         (dismiss_pi),
    .ring_po            (ring_po),
    .snoozed_po         (snoozed_po),
    .snooze_left_po     (snooze_left_po),
    .snooze_count_po    (snooze_count_po)
  );

  initial clk_pi = 1'b0;
  always #5 clk_pi = ~clk_pi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = IDLE;
    m_rem  = 0;
    m_left = 0;
    m_cnt  = 0;
  endtask

  // Advance the model by one active edge using the inputs it saw.
  task automatic model_step();
    if (!alarm_en_pi) begin
      model_reset();
    end else begin
      case (m_st)
        IDLE: if (alarm_triggered_pi) begin
          m_st = RINGING; m_rem = RING; m_cnt = 0;
        end
        RINGING: begin
          if (dismiss_pi) m_st = DONE;
          else if (snooze_pi && m_cnt < MAXS) begin
            m_st = SNOOZED; m_left = SNZ; m_cnt++;
          end else if (sec_en_pi) begin
            m_rem--;
            if (m_rem == 0) m_st = DONE;
          end
        end
        SNOOZED: begin
          if (dismiss_pi) begin
            m_st = DONE; m_left = 0;
          end else if (sec_en_pi) begin
            m_left--;
            if (m_left == 0) begin
              m_st = RINGING; m_rem = RING;
            end
          end
        end
        default: if (!alarm_triggered_pi) m_st = IDLE;
      endcase
    end
  endtask

  // One clock: drive on the falling edge, predict at the rising edge,
  // compare one time unit later.
  task automatic tick(input logic snz, input logic dis);
    exp_t e;
    @(negedge clk_pi);
    sec_en_pi  = (cyc % 10 == 9);
    snooze_pi  = snz;
    dismiss_pi = dis;
    @(posedge clk_pi);
    model_step();
    e.ring    = (m_st == RINGING);
    e.snoozed = (m_st == SNOOZED);
    e.left    = m_left;
    e.count   = m_cnt;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check("ring",    32'(ring_po),         32'(e.ring));
    check("snoozed", 32'(snoozed_po),      32'(e.snoozed));
    check("left",    32'(snooze_left_po),  32'(e.left));
    check("count",   32'(snooze_count_po), 32'(e.count));
    cyc++;
  endtask

  // Idle-tick until the next tick will carry a second pulse.
  task automatic run_to_pulse();
    for (int i = 0; i < 10 && (cyc % 10) != 9; i++) tick(1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ring"},    32'(ring_po),         32'd0);
    check({tag, "_snoozed"}, 32'(snoozed_po),      32'd0);
    check({tag, "_left"},    32'(snooze_left_po),  32'd0);
    check({tag, "_count"},   32'(snooze_count_po), 32'd0);
  endtask

  initial begin
    int pulses;
    rst_n_pi           = 1'b0;
    sec_en_pi          = 1'b0;
    alarm_en_pi        = 1'b1;
    alarm_triggered_pi = 1'b0;
    snooze_pi          = 1'b0;
    dismiss_pi         = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk_pi);
    #2 rst_n_pi = 1'b1;
    tick(1'b0, 1'b0);

    // 1: ring, auto-silence after exactly RING pulses, disable back to idle.
    alarm_triggered_pi = 1'b1;
    tick(1'b0, 1'b0);
    check("t1_ring_on", 32'(ring_po), 32'd1);
    pulses = 0;
    for (int i = 0; i < 100 && ring_po; i++) begin
      if (cyc % 10 == 9) pulses++;
      tick(1'b0, 1'b0);
    end
    check("t1_pulses", 32'(pulses), 32'(RING));
    check("t1_silenced", 32'(ring_po), 32'd0);
    alarm_en_pi = 1'b0;
    alarm_triggered_pi = 1'b0;
    tick(1'b0, 1'b0);
    check_all_zero("t1_idle");
    alarm_en_pi = 1'b1;
    tick(1'b0, 1'b0);

    // 2: snooze, count down 3-2-1, re-ring.
    alarm_triggered_pi = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("t2_snoozed", 32'(snoozed_po), 32'd1);
    check("t2_left3", 32'(snooze_left_po), 32'd3);
    check("t2_count1", 32'(snooze_count_po), 32'd1);
    run_to_pulse(); tick(1'b0, 1'b0);
    check("t2_left2", 32'(snooze_left_po), 32'd2);
    run_to_pulse(); tick(1'b0, 1'b0);
    check("t2_left1", 32'(snooze_left_po), 32'd1);
    run_to_pulse(); tick(1'b0, 1'b0);
    check("t2_rering", 32'(ring_po), 32'd1);
    check("t2_left0", 32'(snooze_left_po), 32'd0);

    // 3: second snooze, then a third press is ignored.
    tick(1'b1, 1'b0);
    check("t3_count2", 32'(snooze_count_po), 32'd2);
    for (int i = 0; i < 40 && !ring_po; i++) tick(1'b0, 1'b0);
    check("t3_rering", 32'(ring_po), 32'd1);
    tick(1'b1, 1'b0);
    check("t3_ignored_ring", 32'(ring_po), 32'd1);
    check("t3_ignored_count", 32'(snooze_count_po), 32'd2);

    // 4: dismiss beats snooze; no re-ring while trigger is held.
    tick(1'b1, 1'b1);
    check("t4_done_ring", 32'(ring_po), 32'd0);
    check("t4_done_snz", 32'(snoozed_po), 32'd0);
    check("t4_count", 32'(snooze_count_po), 32'd2);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
    check("t4_still_quiet", 32'(ring_po), 32'd0);

    // 5: snooze on the expiry pulse wins; disable clears everything.
    alarm_en_pi = 1'b0;
    tick(1'b0, 1'b0);
    alarm_en_pi = 1'b1;
    tick(1'b0, 1'b0);
    check("t5_ring", 32'(ring_po), 32'd1);
    for (int k = 0; k < RING - 1; k++) begin
      run_to_pulse();
      tick(1'b0, 1'b0);
    end
    run_to_pulse();
    tick(1'b1, 1'b0);
    check("t5_snoozed", 32'(snoozed_po), 32'd1);
    check("t5_not_done", 32'(ring_po), 32'd0);
    alarm_en_pi = 1'b0;
    tick(1'b0, 1'b0);
    check_all_zero("t5_disabled");
    alarm_en_pi = 1'b1;

    // 6: asynchronous reset mid-snooze, re-ring after release.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("t6_pre_snoozed", 32'(snoozed_po), 32'd1);
    #2 rst_n_pi = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(posedge clk_pi);
    #2 rst_n_pi = 1'b1;
    tick(1'b0, 1'b0);
    check("t6_rering", 32'(ring_po), 32'd1);
    check("t6_count0", 32'(snooze_count_po), 32'd0);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Ring/snooze controller downstream of each `alarm_fsm` instance. It consumes the level `alarm_triggered_po` and the one-per-second enable from `seconds_clkdiv`, and produces a Moore-style ring output with snooze, dismiss and auto-silence behaviour. The top level drives LED/blink logic from `ring_po` instead of the raw trigger. One instance is used per alarm.

## Interface
Parameters:
- `SNOOZE_SEC`, default 300: snooze length, in second ticks.
- `RING_SEC`, default 60: ring length before auto-silence, in second ticks; must be ≥1.
- `MAX_SNOOZES`, default 3: snoozes allowed per alarm event; must be ≥1.

Ports:
- `clk_pi` in 1: system clock.
- `rst_n_pi` in 1: reset; asynchronous, active-low.
- `sec_en_pi` in 1: one-cycle pulse, once per second.
- `alarm_en_pi` in 1: alarm enable switch.
- `alarm_triggered_pi` in 1: level from `alarm_fsm`.
- `snooze_pi` in 1: debounced one-cycle press.
- `dismiss_pi` in 1: debounced one-cycle press.
- `ring_po` out 1: high while ringing.
- `snoozed_po` out 1: high while snoozed.
- `snooze_left_po` out `$clog2(SNOOZE_SEC+1)`: seconds remaining in the snooze; 0 when not snoozed.
- `snooze_count_po` out `$clog2(MAX_SNOOZES+1)`: snoozes used in the current event.

## Operation
- States:
  - IDLE=0
  - RINGING=1
  - SNOOZED=2
  - DONE=3
- Priority in every state: `alarm_en_pi`=0 → IDLE, with all counters cleared.
- IDLE: `alarm_triggered_pi`=1 → RINGING. On entry, ring timer=0 and snooze_count=0.
- RINGING, in priority order:
  - `dismiss_pi` → DONE.
  - else `snooze_pi` with snooze_count<MAX_SNOOZES → SNOOZED. Snooze timer loads SNOOZE_SEC; snooze_count increments.
  - else `sec_en_pi` with ring timer==RING_SEC-1 → DONE (auto-silence).
  - else `sec_en_pi` → ring timer increments.
  - `snooze_pi` with snooze_count==MAX_SNOOZES is ignored.
- SNOOZED, in priority order:
  - `dismiss_pi` → DONE; snooze timer cleared.
  - else `sec_en_pi` with snooze timer==1 → RINGING; snooze timer=0 and ring timer=0.
  - else `sec_en_pi` → snooze timer decrements.
  - `snooze_pi` is ignored.
- DONE: `alarm_triggered_pi`=0 → IDLE. This blocks re-ringing within the same matching minute. Because `alarm_fsm` holds its trigger until the enable drops, leaving DONE normally happens through `alarm_en_pi`=0.
- Outputs are pure decodes of registered state and counters:
  - `ring_po` = (state==RINGING).
  - `snoozed_po` = (state==SNOOZED).
  - `snooze_left_po` = snooze timer.
  - `snooze_count_po` = snooze_count.
- Arithmetic: the ring timer is `$clog2(RING_SEC)` bits and never exceeds RING_SEC-1. The snooze timer never wraps. snooze_count saturates at MAX_SNOOZES.

## Timing
- Reset values: state=IDLE, all counters 0, so `ring_po`=0, `snoozed_po`=0, `snooze_left_po`=0, `snooze_count_po`=0.
- Asynchronous assert. Release is honoured on the next `clk_pi` edge.
- Latency: an input event sampled at edge N is visible on the outputs after edge N (1 cycle).
- Ring duration: exactly RING_SEC `sec_en_pi` pulses after entry. The wall-clock duration is therefore between RING_SEC-1 and RING_SEC seconds.
- Snooze duration: exactly SNOOZE_SEC `sec_en_pi` pulses.
- Simultaneous events:
  - `dismiss_pi` beats `snooze_pi`, which beats `sec_en_pi` expiry.
  - `alarm_en_pi`=0 beats everything.
- Reset mid-ring or mid-snooze returns to IDLE. If `alarm_triggered_pi` is still high, the block re-rings on the next cycle with snooze_count=0.

## Structure
- The state encodings (IDLE/RINGING/SNOOZED/DONE) live as localparams in the shared `alarm_clock_pkg` include, so the top level and the bench decode them identically.
- One sub-module is natural: `sec_timer`. It is a loadable, clearable up/down counter advanced by `sec_en_pi`, with a terminal-count flag. The block instantiates it twice: ring timer counting up, snooze timer counting down.

## Test plan
Bench parameters: SNOOZE_SEC=3, RING_SEC=4, MAX_SNOOZES=2, with `sec_en_pi` pulsed every 10 cycles.

1. Raise `alarm_triggered_pi` → `ring_po`=1 one cycle later. After 4 `sec_en_pi` pulses → `ring_po`=0 (DONE). Drop `alarm_en_pi` → IDLE.
2. Ringing, pulse `snooze_pi` → `snoozed_po`=1, `snooze_left_po`=3, `snooze_count_po`=1. `snooze_left_po` steps 3→2→1, and the third tick gives `ring_po`=1, `snooze_left_po`=0.
3. Snooze twice, then a third `snooze_pi` while ringing → ignored. `ring_po` stays 1 and `snooze_count_po` stays 2.
4. `snooze_pi` and `dismiss_pi` in the same cycle while ringing → DONE, `snooze_count_po` unchanged. Keep `alarm_triggered_pi`=1 for 100 cycles → `ring_po` stays 0.
5. `snooze_pi` coincident with the 4th `sec_en_pi` → SNOOZED, not DONE. `alarm_en_pi`=0 during SNOOZED → all outputs 0 next cycle.
6. Assert `rst_n_pi`=0 asynchronously mid-snooze → all outputs 0 immediately. Release with trigger still high → `ring_po`=1 one cycle after the first active edge, `snooze_count_po`=0.
